cpu_param: RTL

CPU_PARAM -- requirements
Module: cpu_param

---
 rtl/cpu_param.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_param.sv
// cpu_param: multi-cycle 16-bit load/store CPU, eight registers, C result register, Z/N/V flags.
// Ports: clk, rst_n (async active-low); start_pc boot address; mem_req/mem_we/mem_addr/mem_wdata/
//        mem_rdata/mem_ack memory handshake; out = C register; halted = HALT or ERR; err = ERR.
// Config: define CPU_PARAM_BRANCH_EN to add conditional branches on opcode 001 (otherwise 001 is illegal).
module cpu_param #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] REG_INIT = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] start_pc,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       out,
    output logic              halted,
    output logic              err
);

    localparam logic [3:0] S_RESET  = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_READ   = 4'd3;
    localparam logic [3:0] S_ALU    = 4'd4;
    localparam logic [3:0] S_MEM    = 4'd5;
    localparam logic [3:0] S_WB     = 4'd6;
    localparam logic [3:0] S_HALT   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    logic [3:0]        state;
    logic              boot;     // RESET lingers one extra cycle after rst_n rises
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [15:0]       opa;      // Rn operand
    logic [15:0]       opb;      // shifted Rm, or imm5 for LDR/STR
    logic [15:0]       c;
    logic [15:0]       mdr;
    logic [15:0]       regs [0:7];
    logic              flag_z, flag_n, flag_v;

    // Instruction fields
    logic [2:0]  op, rn, rd, rm;
    logic [1:0]  alu, sh;
    logic [15:0] imm8_sx, imm5_sx;

    assign op      = ir[15:13];
    assign alu     = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign rm      = ir[2:0];
    assign imm8_sx = {{8{ir[7]}}, ir[7:0]};
    assign imm5_sx = {{11{ir[4]}}, ir[4:0]};

    logic is_movi, is_movr, is_arith, is_cmp, is_ldr, is_str, is_halt, is_legal;

    assign is_movi  = (op == 3'b110) && (alu == 2'b10);
    assign is_movr  = (op == 3'b110) && (alu == 2'b00);
    assign is_arith = (op == 3'b101);                 // ADD / CMP / AND / MVN
    assign is_cmp   = is_arith && (alu == 2'b01);
    assign is_ldr   = (op == 3'b011) && (alu == 2'b00);
    assign is_str   = (op == 3'b100) && (alu == 2'b00);
    assign is_halt  = (op == 3'b111);
    assign is_legal = is_movi | is_movr | is_arith | is_ldr | is_str | is_halt;

    function automatic logic [15:0] shift_op(input logic [15:0] v, input logic [1:0] code);
        case (code)
            2'b01:   shift_op = {v[14:0], 1'b0};
            2'b10:   shift_op = {1'b0, v[15:1]};
            2'b11:   shift_op = {v[15], v[15:1]};
            default: shift_op = v;
        endcase
    endfunction

    logic [15:0] diff;
    logic [15:0] alu_res;

    assign diff = opa - opb;

    // ADD result doubles as the LDR/STR effective address.
    always_comb begin
        alu_res = opa + opb;
        if (is_movr) begin
            alu_res = opb;
        end else if (is_arith) begin
            case (alu)
                2'b01:   alu_res = diff;
                2'b10:   alu_res = opa & opb;
                2'b11:   alu_res = ~opb;
                default: alu_res = opa + opb;
            endcase
        end
    end

`ifdef CPU_PARAM_BRANCH_EN
    logic is_br, br_taken;

    assign is_br = (op == 3'b001) && (rn <= 3'd4);

    always_comb begin
        br_taken = 1'b0;
        case (rn)
            3'd0:    br_taken = 1'b1;
            3'd1:    br_taken = flag_z;
            3'd2:    br_taken = ~flag_z;
            3'd3:    br_taken = flag_n ^ flag_v;
            3'd4:    br_taken = flag_z | (flag_n ^ flag_v);
            default: br_taken = 1'b0;
        endcase
    end
`else
    // Without branches nothing consumes the flags; they are still kept architecturally.
    logic unused_flags;
    assign unused_flags = flag_z ^ flag_n ^ flag_v;
`endif

    // Single synchronous register-file write port, active only in WB.
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [15:0] wr_dat;

    always_comb begin
        wr_en  = (state == S_WB);
        wr_idx = rd;
        wr_dat = c;
        if (is_movi) begin
            wr_idx = rn;
            wr_dat = imm8_sx;
        end else if (is_ldr) begin
            wr_dat = mdr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) regs[i] <= REG_INIT;
        end else if (wr_en) begin
            regs[wr_idx] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_RESET;
            boot   <= 1'b0;
            pc     <= '0;
            ir     <= 16'h0;
            opa    <= 16'h0;
            opb    <= 16'h0;
            c      <= 16'h0;
            mdr    <= 16'h0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    pc   <= start_pc;
                    boot <= 1'b1;
                    if (boot) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    pc <= pc + ADDR_W'(1);
                    if (is_halt) begin
                        state <= S_HALT;
                    end else if (is_movi) begin
                        state <= S_WB;
`ifdef CPU_PARAM_BRANCH_EN
                    end else if (is_br) begin
                        if (br_taken) pc <= pc + ADDR_W'(1) + ADDR_W'(imm8_sx);
                        state <= S_FETCH;
`endif
                    end else if (is_legal) begin
                        state <= S_READ;
                    end else begin
                        state <= S_ERR;
                    end
                end
                S_READ: begin
                    opa   <= regs[rn];
                    opb   <= (is_ldr || is_str) ? imm5_sx : shift_op(regs[rm], sh);
                    state <= S_ALU;
                end
                S_ALU: begin
                    c <= alu_res;
                    if (is_cmp) begin
                        flag_z <= (diff == 16'h0);
                        flag_n <= diff[15];
                        flag_v <= (opa[15] ^ opb[15]) & (diff[15] ^ opa[15]);
                        state  <= S_FETCH;
                    end else if (is_ldr || is_str) begin
                        state <= S_MEM;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mdr   <= mem_rdata;
                        state <= is_ldr ? S_WB : S_FETCH;
                    end
                end
                S_WB:    state <= S_FETCH;
                S_HALT:  state <= S_HALT;
                S_ERR:   state <= S_ERR;
                default: state <= S_ERR;
            endcase
        end
    end

    // Memory outputs decode straight from state so reset drops them immediately.
    assign mem_req   = (state == S_FETCH) || (state == S_MEM);
    assign mem_we    = (state == S_MEM) && is_str;
    assign mem_addr  = (state == S_FETCH) ? pc :
                       (state == S_MEM)   ? c[ADDR_W-1:0] : '0;
    assign mem_wdata = mem_we ? regs[rd] : 16'h0;
    assign out       = c;
    assign halted    = (state == S_HALT) || (state == S_ERR);
    assign err       = (state == S_ERR);

endmodule
